// File: rtl/sd_data_xfer_sched.sv
// Transfer scheduler for the 4-bit SD data path: read/write arbitration, CRC retry, timeout.
// Optional SD_XFER_STATS_EN adds saturating completion/retry counters on the Stat_* ports.
module sd_data_xfer_sched #(
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned RETRY_GAP      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd_Req,
    input  logic [31:0] Rd_Blocks,
    output logic        Rd_Ack,
    input  logic        Wr_Req,
    input  logic [31:0] Wr_Blocks,
    output logic        Wr_Ack,
    output logic        Xfer_Done,
    output logic        Xfer_Is_Write,
    output logic [1:0]  Xfer_Status,
    output logic        Busy,
    output logic        Get_DATA_En,
    input  logic        Get_DATA_Complite,
    input  logic        Get_DATA_CRC_Fail,
    output logic        Send_DATA_En,
    input  logic        Send_DATA_Complite,
    output logic [31:0] BlockReadCount,
    output logic [31:0] BlockWriteCount,
    output logic [15:0] Stat_Rd_Ok,
    output logic [15:0] Stat_Wr_Ok,
    output logic [15:0] Stat_Retries
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned GW = (RETRY_GAP < 2) ? 1 : $clog2(RETRY_GAP);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP - 1);

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_CRC  = 2'd1;
    localparam logic [1:0] ST_TMO  = 2'd2;
    localparam logic [1:0] ST_ZERO = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRdRun,
        StWrRun,
        StGap,
        StDone
    } state_e;

    state_e        state_q;
    logic          wr_pref_q;
    logic          is_wr_q;
    logic [RW-1:0] retry_q;
    logic [GW-1:0] gap_q;
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            wr_pref_q       <= 1'b0;
            is_wr_q         <= 1'b0;
            retry_q         <= '0;
            gap_q           <= '0;
            tmo_q           <= '0;
            Rd_Ack          <= 1'b0;
            Wr_Ack          <= 1'b0;
            Xfer_Done       <= 1'b0;
            Xfer_Is_Write   <= 1'b0;
            Xfer_Status     <= 2'd0;
            Busy            <= 1'b0;
            Get_DATA_En     <= 1'b0;
            Send_DATA_En    <= 1'b0;
            BlockReadCount  <= '0;
            BlockWriteCount <= '0;
`ifdef SD_XFER_STATS_EN
            Stat_Rd_Ok      <= '0;
            Stat_Wr_Ok      <= '0;
            Stat_Retries    <= '0;
`endif
        end else begin
            Rd_Ack    <= 1'b0;
            Wr_Ack    <= 1'b0;
            Xfer_Done <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    // Read wins unless a write is also pending and writes have the turn.
                    if (Rd_Req && (!Wr_Req || !wr_pref_q)) begin
                        Rd_Ack         <= 1'b1;
                        BlockReadCount <= Rd_Blocks;
                        Busy           <= 1'b1;
                        is_wr_q        <= 1'b0;
                        retry_q        <= '0;
                        tmo_q          <= '0;
                        state_q        <= StRdRun;
                        if (Wr_Req) wr_pref_q <= 1'b1;
                    end else if (Wr_Req) begin
                        Wr_Ack          <= 1'b1;
                        BlockWriteCount <= Wr_Blocks;
                        Busy            <= 1'b1;
                        is_wr_q         <= 1'b1;
                        retry_q         <= '0;
                        tmo_q           <= '0;
                        state_q         <= StWrRun;
                        if (Rd_Req) wr_pref_q <= 1'b0;
                    end
                end

                StRdRun: begin
                    // Enable low here means either the Ack cycle or a zero-block request.
                    if (!Get_DATA_En) begin
                        if (Rd_Ack) begin
                            if (BlockReadCount != 32'd0) Get_DATA_En <= 1'b1;
                        end else begin
                            Xfer_Done     <= 1'b1;
                            Xfer_Status   <= ST_ZERO;
                            Xfer_Is_Write <= 1'b0;
                            state_q       <= StDone;
                        end
                    end else if (Get_DATA_CRC_Fail) begin
                        Get_DATA_En <= 1'b0;
                        tmo_q       <= '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 1'b1;
                            gap_q   <= '0;
                            state_q <= StGap;
`ifdef SD_XFER_STATS_EN
                            if (Stat_Retries != 16'hFFFF) Stat_Retries <= Stat_Retries + 16'd1;
`endif
                        end else begin
                            Xfer_Done     <= 1'b1;
                            Xfer_Status   <= ST_CRC;
                            Xfer_Is_Write <= 1'b0;
                            state_q       <= StDone;
                        end
                    end else if (Get_DATA_Complite) begin
                        Get_DATA_En   <= 1'b0;
                        Xfer_Done     <= 1'b1;
                        Xfer_Status   <= ST_OK;
                        Xfer_Is_Write <= 1'b0;
                        state_q       <= StDone;
                    end else if (tmo_q == TMO_LAST) begin
                        Get_DATA_En   <= 1'b0;
                        Xfer_Done     <= 1'b1;
                        Xfer_Status   <= ST_TMO;
                        Xfer_Is_Write <= 1'b0;
                        state_q       <= StDone;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                StWrRun: begin
                    if (!Send_DATA_En) begin
                        if (Wr_Ack) begin
                            if (BlockWriteCount != 32'd0) Send_DATA_En <= 1'b1;
                        end else begin
                            Xfer_Done     <= 1'b1;
                            Xfer_Status   <= ST_ZERO;
                            Xfer_Is_Write <= 1'b1;
                            state_q       <= StDone;
                        end
                    end else if (Send_DATA_Complite) begin
                        Send_DATA_En  <= 1'b0;
                        Xfer_Done     <= 1'b1;
                        Xfer_Status   <= ST_OK;
                        Xfer_Is_Write <= 1'b1;
                        state_q       <= StDone;
                    end else if (tmo_q == TMO_LAST) begin
                        Send_DATA_En  <= 1'b0;
                        Xfer_Done     <= 1'b1;
                        Xfer_Status   <= ST_TMO;
                        Xfer_Is_Write <= 1'b1;
                        state_q       <= StDone;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                StGap: begin
                    // Re-arm on the last gap edge so the enable is low exactly RETRY_GAP cycles.
                    if (gap_q == GAP_LAST) begin
                        Get_DATA_En <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= StRdRun;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end

                StDone: begin
                    Busy    <= 1'b0;
                    state_q <= StIdle;
`ifdef SD_XFER_STATS_EN
                    if (Xfer_Status == ST_OK) begin
                        if (Xfer_Is_Write) begin
                            if (Stat_Wr_Ok != 16'hFFFF) Stat_Wr_Ok <= Stat_Wr_Ok + 16'd1;
                        end else begin
                            if (Stat_Rd_Ok != 16'hFFFF) Stat_Rd_Ok <= Stat_Rd_Ok + 16'd1;
                        end
                    end
`endif
                end

                default: begin
                    Get_DATA_En  <= 1'b0;
                    Send_DATA_En <= 1'b0;
                    Busy         <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

`ifndef SD_XFER_STATS_EN
    assign Stat_Rd_Ok   = 16'd0;
    assign Stat_Wr_Ok   = 16'd0;
    assign Stat_Retries = 16'd0;
`endif

endmodule

// File: tb/tb_sd_data_xfer_sched.sv
// Directed bench for sd_data_xfer_sched: arbitration, retry gaps, timeout, zero-block, reset.
module tb_sd_data_xfer_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        Rd_Req, Wr_Req;
    logic [31:0] Rd_Blocks, Wr_Blocks;
    logic        Rd_Ack, Wr_Ack;
    logic        Xfer_Done, Xfer_Is_Write, Busy;
    logic [1:0]  Xfer_Status;
    logic        Get_DATA_En, Get_DATA_Complite, Get_DATA_CRC_Fail;
    logic        Send_DATA_En, Send_DATA_Complite;
    logic [31:0] BlockReadCount, BlockWriteCount;
    logic [15:0] Stat_Rd_Ok, Stat_Wr_Ok, Stat_Retries;

    int total = 0;
    int bad = 0;
    int overlap = 0;
    int done_seen = 0;

`ifdef SD_XFER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    sd_data_xfer_sched #(
        .MAX_RETRY     (3),
        .RETRY_GAP     (8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .Rd_Req            (Rd_Req),
        .Rd_Blocks         (Rd_Blocks),
        .Rd_Ack            (Rd_Ack),
        .Wr_Req            (Wr_Req),
        .Wr_Blocks         (Wr_Blocks),
        .Wr_Ack            (Wr_Ack),
        .Xfer_Done         (Xfer_Done),
        .Xfer_Is_Write     (Xfer_Is_Write),
        .Xfer_Status       (Xfer_Status),
        .Busy              (Busy),
        .Get_DATA_En       (Get_DATA_En),
        .Get_DATA_Complite (Get_DATA_Complite),
        .Get_DATA_CRC_Fail (Get_DATA_CRC_Fail),
        .Send_DATA_En      (Send_DATA_En),
        .Send_DATA_Complite(Send_DATA_Complite),
        .BlockReadCount    (BlockReadCount),
        .BlockWriteCount   (BlockWriteCount),
        .Stat_Rd_Ok        (Stat_Rd_Ok),
        .Stat_Wr_Ok        (Stat_Wr_Ok),
        .Stat_Retries      (Stat_Retries)
    );

    always @(negedge clk) begin
        if (Get_DATA_En && Send_DATA_En) overlap++;
        if (Xfer_Done) done_seen++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; Rd_Req = 0; Wr_Req = 0; Rd_Blocks = 0; Wr_Blocks = 0;
        Get_DATA_Complite = 0; Get_DATA_CRC_Fail = 0; Send_DATA_Complite = 0;
        tick; tick;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
        total++; if ({Get_DATA_En, Send_DATA_En} !== 2'b00) begin bad++; $display("FAIL reset_en got=%b want=00", {Get_DATA_En, Send_DATA_En}); end
        total++; if ({Rd_Ack, Wr_Ack, Xfer_Done} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {Rd_Ack, Wr_Ack, Xfer_Done}); end
        total++; if ({BlockReadCount, BlockWriteCount} !== 64'd0) begin bad++; $display("FAIL reset_counts got=%h want=0", {BlockReadCount, BlockWriteCount}); end
        total++; if ({Xfer_Status, Xfer_Is_Write} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {Xfer_Status, Xfer_Is_Write}); end
        total++; if ({Stat_Rd_Ok, Stat_Wr_Ok, Stat_Retries} !== 48'd0) begin bad++; $display("FAIL reset_stats got=%h want=0", {Stat_Rd_Ok, Stat_Wr_Ok, Stat_Retries}); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_read_basic;
        Rd_Req = 1; Rd_Blocks = 32'd4; tick;
        total++; if (Rd_Ack !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b want=1", Rd_Ack); end
        total++; if (Get_DATA_En !== 1'b0) begin bad++; $display("FAIL rd_en_ack_cycle got=%b want=0", Get_DATA_En); end
        total++; if (BlockReadCount !== 32'd4) begin bad++; $display("FAIL rd_count got=%0d want=4", BlockReadCount); end
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rd_busy got=%b want=1", Busy); end
        Rd_Req = 0; Rd_Blocks = 32'd77; tick;
        total++; if ({Rd_Ack, Get_DATA_En} !== 2'b01) begin bad++; $display("FAIL rd_en_rise got=%b want=01", {Rd_Ack, Get_DATA_En}); end
        repeat (49) tick;
        Get_DATA_Complite = 1; tick; Get_DATA_Complite = 0;
        total++; if ({Xfer_Done, Xfer_Status, Xfer_Is_Write} !== 4'b1000) begin bad++; $display("FAIL rd_done got=%b want=1000", {Xfer_Done, Xfer_Status, Xfer_Is_Write}); end
        total++; if ({Get_DATA_En, Busy} !== 2'b01) begin bad++; $display("FAIL rd_done_en_busy got=%b want=01", {Get_DATA_En, Busy}); end
        total++; if (BlockReadCount !== 32'd4) begin bad++; $display("FAIL rd_count_stable got=%0d want=4", BlockReadCount); end
        tick;
        total++; if ({Busy, Xfer_Done} !== 2'b00) begin bad++; $display("FAIL rd_after_done got=%b want=00", {Busy, Xfer_Done}); end
        // Completion strobes in IDLE must not produce anything.
        Get_DATA_Complite = 1; Send_DATA_Complite = 1; tick; tick;
        Get_DATA_Complite = 0; Send_DATA_Complite = 0;
        total++; if ({Xfer_Done, Busy, Get_DATA_En, Send_DATA_En} !== 4'b0000) begin bad++; $display("FAIL idle_ignore got=%b want=0000", {Xfer_Done, Busy, Get_DATA_En, Send_DATA_En}); end
    endtask

    task automatic test_arbitration;
        int n;
        Rd_Req = 1; Wr_Req = 1; Rd_Blocks = 32'd1; Wr_Blocks = 32'd2; tick;
        total++; if ({Rd_Ack, Wr_Ack} !== 2'b10) begin bad++; $display("FAIL arb1_first got=%b want=10", {Rd_Ack, Wr_Ack}); end
        Rd_Req = 0; tick;
        Get_DATA_Complite = 1; tick; Get_DATA_Complite = 0;
        total++; if ({Xfer_Done, Xfer_Is_Write} !== 2'b10) begin bad++; $display("FAIL arb1_rd_done got=%b want=10", {Xfer_Done, Xfer_Is_Write}); end
        n = 0; while (!Wr_Ack && n < 10) begin tick; n++; end
        total++; if (n !== 2) begin bad++; $display("FAIL arb1_wr_ack_delay got=%0d want=2", n); end
        total++; if (BlockWriteCount !== 32'd2) begin bad++; $display("FAIL arb1_wr_count got=%0d want=2", BlockWriteCount); end
        Wr_Req = 0; tick;
        Send_DATA_Complite = 1; tick; Send_DATA_Complite = 0;
        total++; if ({Xfer_Done, Xfer_Status, Xfer_Is_Write} !== 4'b1001) begin bad++; $display("FAIL arb1_wr_done got=%b want=1001", {Xfer_Done, Xfer_Status, Xfer_Is_Write}); end
        tick;
        Rd_Req = 1; Wr_Req = 1; tick;
        total++; if ({Rd_Ack, Wr_Ack} !== 2'b01) begin bad++; $display("FAIL arb2_first got=%b want=01", {Rd_Ack, Wr_Ack}); end
        Wr_Req = 0; tick;
        // Read-engine strobes while writing belong to the inactive engine.
        Get_DATA_Complite = 1; Get_DATA_CRC_Fail = 1; tick;
        Get_DATA_Complite = 0; Get_DATA_CRC_Fail = 0;
        total++; if ({Xfer_Done, Send_DATA_En} !== 2'b01) begin bad++; $display("FAIL arb2_ignore_get got=%b want=01", {Xfer_Done, Send_DATA_En}); end
        Send_DATA_Complite = 1; tick; Send_DATA_Complite = 0;
        total++; if ({Xfer_Done, Xfer_Is_Write} !== 2'b11) begin bad++; $display("FAIL arb2_wr_done got=%b want=11", {Xfer_Done, Xfer_Is_Write}); end
        n = 0; while (!Rd_Ack && n < 10) begin tick; n++; end
        total++; if (n !== 2) begin bad++; $display("FAIL arb2_rd_ack_delay got=%0d want=2", n); end
        Rd_Req = 0; tick;
        Get_DATA_Complite = 1; tick; Get_DATA_Complite = 0;
        total++; if ({Xfer_Done, Xfer_Is_Write} !== 2'b10) begin bad++; $display("FAIL arb2_rd_done got=%b want=10", {Xfer_Done, Xfer_Is_Write}); end
        tick;
        total++; if (overlap !== 0) begin bad++; $display("FAIL enable_overlap got=%0d want=0", overlap); end
    endtask

    task automatic test_retry;
        int lo;
        Rd_Req = 1; Rd_Blocks = 32'd2; tick; Rd_Req = 0; tick;
        for (int r = 0; r < 3; r++) begin
            Get_DATA_CRC_Fail = 1; tick; Get_DATA_CRC_Fail = 0;
            lo = 0; while (!Get_DATA_En && lo < 20) begin lo++; tick; end
            total++; if (lo !== 8) begin bad++; $display("FAIL retry_gap%0d got=%0d want=8", r, lo); end
        end
        total++; if ({BlockReadCount, Xfer_Done} !== {32'd2, 1'b0}) begin bad++; $display("FAIL retry_count got=%0d/%b want=2/0", BlockReadCount, Xfer_Done); end
        Get_DATA_Complite = 1; tick; Get_DATA_Complite = 0;
        total++; if ({Xfer_Done, Xfer_Status} !== 3'b100) begin bad++; $display("FAIL retry_ok got=%b want=100", {Xfer_Done, Xfer_Status}); end
        tick;
        total++; if (Stat_Retries !== (STATS ? 16'd3 : 16'd0)) begin bad++; $display("FAIL retry_stat got=%0d want=%0d", Stat_Retries, STATS ? 3 : 0); end
        Rd_Req = 1; tick; Rd_Req = 0; tick;
        for (int r = 0; r < 3; r++) begin
            Get_DATA_CRC_Fail = 1; tick; Get_DATA_CRC_Fail = 0;
            lo = 0; while (!Get_DATA_En && lo < 20) begin lo++; tick; end
        end
        // Fourth failure arrives together with Complite; the failure must win.
        Get_DATA_CRC_Fail = 1; Get_DATA_Complite = 1; tick;
        Get_DATA_CRC_Fail = 0; Get_DATA_Complite = 0;
        total++; if ({Xfer_Done, Xfer_Status, Get_DATA_En} !== 4'b1010) begin bad++; $display("FAIL retry_exhaust got=%b want=1010", {Xfer_Done, Xfer_Status, Get_DATA_En}); end
        tick;
    endtask

    task automatic test_timeout;
        int hi;
        Wr_Req = 1; Wr_Blocks = 32'd3; tick; Wr_Req = 0; tick;
        hi = 0; while (Send_DATA_En && hi < 200) begin hi++; tick; end
        total++; if (hi !== 100) begin bad++; $display("FAIL tmo_cycles got=%0d want=100", hi); end
        total++; if ({Xfer_Done, Xfer_Status, Xfer_Is_Write} !== 4'b1101) begin bad++; $display("FAIL tmo_done got=%b want=1101", {Xfer_Done, Xfer_Status, Xfer_Is_Write}); end
        tick;
    endtask

    task automatic test_zero_block;
        Wr_Req = 1; Wr_Blocks = 32'd0; tick; Wr_Req = 0;
        total++; if ({Wr_Ack, Send_DATA_En} !== 2'b10) begin bad++; $display("FAIL zero_ack got=%b want=10", {Wr_Ack, Send_DATA_En}); end
        tick;
        total++; if ({Xfer_Done, Send_DATA_En} !== 2'b00) begin bad++; $display("FAIL zero_mid got=%b want=00", {Xfer_Done, Send_DATA_En}); end
        tick;
        total++; if ({Xfer_Done, Xfer_Status, Xfer_Is_Write, Send_DATA_En} !== 5'b11110) begin bad++; $display("FAIL zero_done got=%b want=11110", {Xfer_Done, Xfer_Status, Xfer_Is_Write, Send_DATA_En}); end
        tick;
    endtask

    task automatic test_reset_mid;
        int d0;
        total++; if ({Stat_Rd_Ok, Stat_Wr_Ok, Stat_Retries} !== (STATS ? {16'd4, 16'd2, 16'd6} : 48'd0)) begin
            bad++; $display("FAIL stats_total got=%h want=%h", {Stat_Rd_Ok, Stat_Wr_Ok, Stat_Retries}, STATS ? {16'd4, 16'd2, 16'd6} : 48'd0);
        end
        Rd_Req = 1; Rd_Blocks = 32'd5; tick; Rd_Req = 0; tick;
        repeat (5) tick;
        total++; if (Get_DATA_En !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", Get_DATA_En); end
        d0 = done_seen;
        rst = 1; tick; rst = 0;
        total++; if ({Get_DATA_En, Busy} !== 2'b00) begin bad++; $display("FAIL rstmid_drop got=%b want=00", {Get_DATA_En, Busy}); end
        repeat (3) tick;
        total++; if (done_seen !== d0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=%0d", done_seen, d0); end
        Rd_Req = 1; Rd_Blocks = 32'd6; tick; Rd_Req = 0;
        total++; if ({Rd_Ack, BlockReadCount} !== {1'b1, 32'd6}) begin bad++; $display("FAIL rstmid_reaccept got=%b/%0d want=1/6", Rd_Ack, BlockReadCount); end
        tick;
        Get_DATA_Complite = 1; tick; Get_DATA_Complite = 0;
        total++; if ({Xfer_Done, Xfer_Status} !== 3'b100) begin bad++; $display("FAIL rstmid_done got=%b want=100", {Xfer_Done, Xfer_Status}); end
        tick;
        total++; if (Stat_Rd_Ok !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL rstmid_stat got=%0d want=%0d", Stat_Rd_Ok, STATS ? 1 : 0); end
    endtask

    initial begin
        test_reset;
        test_read_basic;
        test_arbitration;
        test_retry;
        test_timeout;
        test_zero_block;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
